alu_op_encoder: RTL and testbench
=================================

# alu_op_encoder

Registered decode stage that turns an RV32I instruction's opcode/funct fields into the 4-bit ALU `Operation` code consumed by the EX-stage ALU. It sits between ID and EX and is the producer side of the `Operation` interface. A valid/ready handshake with a 2-entry skid buffer keeps `in_ready` registered. It also flags illegal encodings and counts them.

## Interface
- `OPCODE_LENGTH`, 4: width of the emitted Operation code.
- `CNT_WIDTH`, 16: width of the saturating illegal-instruction counter.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous pipeline flush (branch/jump redirect).
- `in_valid`  in  1  upstream fields valid.
- `in_ready`  out  1  stage can accept; registered.
- `opcode`  in  7  instr[6:0].
- `funct3`  in  3  instr[14:12].
- `funct7`  in  7  instr[31:25].
- `out_valid`  out  1  `out_operation`/`out_illegal` valid.
- `out_ready`  in  1  EX stage accepts.
- `out_operation`  out  `OPCODE_LENGTH`  ALU Operation code.
- `out_illegal`  out  1  encoding not supported.
- `illegal_count`  out  `CNT_WIDTH`  saturating count of accepted illegal encodings.

## Operation
- Operation codes: AND 0000, OR 0001, ADD 0010, JALR 0011, SLT 0100, XOR 0101, SUB 0110, BEQ 1000, BNE 1001, BLT 1010, BGE 1011, SLL 1101, SRL 1110, SRA 1111. Codes 0111 and 1100 are never emitted.
- R-type (0110011):
  - f3 000: ADD when f7==0000000, SUB when f7==0100000.
  - f3 111/110/100/010: AND/OR/XOR/SLT, f7 must be 0.
  - f3 001: SLL, f7 must be 0.
  - f3 101: SRL when f7==0, SRA when f7==0100000.
  - f3 011 (SLTU), or any other f7, is illegal.
- I-ALU (0010011): same f3 map with f3 000 giving ADD (ADDI; f7 ignored except for shifts). SLLI requires f7==0. SRLI/SRAI are selected by f7==0 / f7==0100000. Other f7 on shifts, and f3 011, are illegal.
- Load (0000011), store (0100011), LUI (0110111), AUIPC (0010111), JAL (1101111): ADD.
- JALR (1100111, f3 000): JALR code 0011. Any other f3 is illegal.
- Branch (1100011): f3 000/001/100/101 give BEQ/BNE/BLT/BGE. f3 010/011/110/111 are illegal.
- Any other opcode is illegal.
- Illegal entries have `out_operation`=0000 and `out_illegal`=1. They are still passed downstream; trap handling is outside this block.
- `illegal_count` increments by 1 on each accepted (in_valid&&in_ready&&!flush) illegal entry. It saturates at all-ones and is never cleared by flush.

## Timing
- Reset (asynchronous, `rst_n`=0): `out_valid`=0, `out_operation`=0000, `out_illegal`=0, `in_ready`=1, `illegal_count`=0, both buffer entries empty.
- Accept when in_valid&&in_ready&&!flush. Decoded entry appears on the outputs the next cycle: latency 1. Throughput is 1/cycle while `out_ready`=1.
- Output entry is held stable while out_valid&&!out_ready.
- Stalled output plus an accept in the same cycle: the new entry goes to the skid entry, and `in_ready` drops to 0 next cycle.
- `in_ready` returns to 1 the cycle after the skid entry drains into the output register.
- Order is strict FIFO across both entries.
- Simultaneous output pop and input accept with skid empty: output register loads the new entry, `out_valid` stays 1.
- `flush`=1: both entries are cleared at the clock edge, giving `out_valid`=0 and `in_ready`=1 next cycle. Any same-cycle `in_valid` is dropped and not counted. An `out_ready` handshake in the flush cycle still counts as consumed by EX.
- `rst_n` assertion mid-transfer discards all entries immediately.

## Structure
- `alu_pkg`: holds the Operation code localparams (`OP_AND`…`OP_SRA`), the RV32I opcode constants, and the `F7_ALT`=0100000 constant. The EX-stage ALU imports the same package.
- Pure combinational decode function (`decode_op`) in `alu_pkg`.
- One sub-module, `alu_op_skid`: a generic 2-entry valid/ready skid buffer carrying {illegal, operation}. The counter and flush fan-out stay in the top level.

## Test plan
- Reset then stream with `out_ready`=1: ADD (0110011/000/0000000), SUB (f7 0100000), SRAI (0010011/101/0100000), BGE (1100011/101) give 0010, 0110, 1111, 1011 on consecutive cycles, each 1 cycle after accept.
- Illegal encodings: SLTU (0110011/011), branch f3 010, and opcode 1111111 each give out_illegal=1 and op 0000; `illegal_count` reads 3.
- Backpressure: hold `out_ready`=0 while 3 valid inputs are offered. Two are accepted, then `in_ready`=0. Release `out_ready` and the outputs drain in order, with `in_ready`=1 one cycle after the skid entry empties.
- Flush with both entries full and `in_valid`=1: the next cycle shows out_valid=0, in_ready=1, and the count is unchanged.
- Counter saturation with `CNT_WIDTH`=2: 5 illegal accepts give `illegal_count`=3.
- Async reset asserted mid-stall, off a clock edge: outputs immediately show out_valid=0, op 0000, in_ready=1.

Source files
------------

// File: rtl/alu_op_encoder_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU Operation interface: the 4-bit Operation
// codes, the RV32I major opcodes recognised by the decoder, the funct7
// constants, and the pure combinational decode function used by the
// ID/EX encoder stage. The EX-stage ALU imports the same package.
// -----------------------------------------------------------------------------
package alu_pkg;

   localparam int OP_W = 4;

   // Operation codes (0111 and 1100 are never produced)
   localparam logic [OP_W-1:0] OP_AND  = 4'b0000;
   localparam logic [OP_W-1:0] OP_OR   = 4'b0001;
   localparam logic [OP_W-1:0] OP_ADD  = 4'b0010;
   localparam logic [OP_W-1:0] OP_JALR = 4'b0011;
   localparam logic [OP_W-1:0] OP_SLT  = 4'b0100;
   localparam logic [OP_W-1:0] OP_XOR  = 4'b0101;
   localparam logic [OP_W-1:0] OP_SUB  = 4'b0110;
   localparam logic [OP_W-1:0] OP_BEQ  = 4'b1000;
   localparam logic [OP_W-1:0] OP_BNE  = 4'b1001;
   localparam logic [OP_W-1:0] OP_BLT  = 4'b1010;
   localparam logic [OP_W-1:0] OP_BGE  = 4'b1011;
   localparam logic [OP_W-1:0] OP_SLL  = 4'b1101;
   localparam logic [OP_W-1:0] OP_SRL  = 4'b1110;
   localparam logic [OP_W-1:0] OP_SRA  = 4'b1111;

   // RV32I major opcodes
   localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
   localparam logic [6:0] OPC_IALU   = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [6:0] F7_ZERO = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef struct packed {
      logic            illegal;
      logic [OP_W-1:0] op;
   } dec_t;

   // Map opcode/funct3/funct7 to an Operation code. Illegal encodings
   // always carry op 0000 so downstream sees a deterministic value.
   function automatic dec_t decode_op(input logic [6:0] opcode,
                                      input logic [2:0] f3,
                                      input logic [6:0] f7);
      dec_t            d;
      logic            ok;
      logic            f7_free;   // I-ALU non-shift: funct7 is immediate bits
      logic [OP_W-1:0] op;
      op      = OP_AND;
      ok      = 1'b0;
      f7_free = (opcode == OPC_IALU);
      case (opcode)
         OPC_RTYPE, OPC_IALU: begin
            case (f3)
               3'b000: begin
                  if (f7_free || (f7 == F7_ZERO)) begin
                     op = OP_ADD;
                     ok = 1'b1;
                  end else if (f7 == F7_ALT) begin
                     op = OP_SUB;
                     ok = 1'b1;
                  end else begin
                     ok = 1'b0;
                  end
               end
               3'b111: begin op = OP_AND; ok = f7_free || (f7 == F7_ZERO); end
               3'b110: begin op = OP_OR;  ok = f7_free || (f7 == F7_ZERO); end
               3'b100: begin op = OP_XOR; ok = f7_free || (f7 == F7_ZERO); end
               3'b010: begin op = OP_SLT; ok = f7_free || (f7 == F7_ZERO); end
               // shifts: funct7 selects the shift kind for both R and I forms
               3'b001: begin op = OP_SLL; ok = (f7 == F7_ZERO); end
               3'b101: begin
                  if (f7 == F7_ZERO) begin
                     op = OP_SRL;
                     ok = 1'b1;
                  end else if (f7 == F7_ALT) begin
                     op = OP_SRA;
                     ok = 1'b1;
                  end else begin
                     ok = 1'b0;
                  end
               end
               default: ok = 1'b0;   // 011: SLTU/SLTIU not supported
            endcase
         end
         OPC_LOAD, OPC_STORE, OPC_LUI, OPC_AUIPC, OPC_JAL: begin
            op = OP_ADD;
            ok = 1'b1;
         end
         OPC_JALR: begin
            op = OP_JALR;
            ok = (f3 == 3'b000);
         end
         OPC_BRANCH: begin
            case (f3)
               3'b000:  begin op = OP_BEQ; ok = 1'b1; end
               3'b001:  begin op = OP_BNE; ok = 1'b1; end
               3'b100:  begin op = OP_BLT; ok = 1'b1; end
               3'b101:  begin op = OP_BGE; ok = 1'b1; end
               default: ok = 1'b0;
            endcase
         end
         default: ok = 1'b0;
      endcase
      d.illegal = ~ok;
      d.op      = ok ? op : OP_AND;
      return d;
   endfunction

endpackage

// File: rtl/alu_op_encoder_skid.sv
// -----------------------------------------------------------------------------
// alu_op_skid
// Generic 2-entry valid/ready skid buffer: an output register plus one skid
// register, strict FIFO order, registered ready.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   i_clr               synchronous clear of both entries
//   i_valid/o_ready     upstream handshake (o_ready registered)
//   i_data              upstream payload
//   o_valid/i_ready     downstream handshake
//   o_data              downstream payload (held while stalled)
// -----------------------------------------------------------------------------
module alu_op_skid #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_clr,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [W-1:0] i_data,
   output logic         o_valid,
   input  logic         i_ready,
   output logic [W-1:0] o_data
);

   logic         r_out_valid;
   logic [W-1:0] r_out_data;
   logic         r_skid_valid;
   logic [W-1:0] r_skid_data;
   logic         r_ready;
   logic         w_push;
   logic         w_pop;

   // r_ready mirrors an empty skid entry, so a push never meets a full skid
   assign w_push = i_valid && r_ready && !i_clr;
   assign w_pop  = r_out_valid && i_ready;

   // Entry storage: output register first, overflow into the skid entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_skid_valid <= 1'b0;
         r_skid_data  <= '0;
         r_ready      <= 1'b1;
      end else if (i_clr) begin
         r_out_valid  <= 1'b0;
         r_skid_valid <= 1'b0;
         r_ready      <= 1'b1;
      end else if (r_skid_valid) begin
         // ready is low here, so only a drain can happen
         if (w_pop) begin
            r_out_data   <= r_skid_data;
            r_skid_valid <= 1'b0;
            r_ready      <= 1'b1;
         end
      end else if (!r_out_valid || w_pop) begin
         r_out_valid <= w_push;
         if (w_push) begin
            r_out_data <= i_data;
         end
      end else if (w_push) begin
         // output stalled: park the new entry and stop accepting
         r_skid_valid <= 1'b1;
         r_skid_data  <= i_data;
         r_ready      <= 1'b0;
      end
   end

   assign o_ready = r_ready;
   assign o_valid = r_out_valid;
   assign o_data  = r_out_data;

endmodule

// File: rtl/alu_op_encoder.sv
// -----------------------------------------------------------------------------
// alu_op_encoder
// Registered ID->EX stage that decodes RV32I opcode/funct fields into the
// ALU Operation code, flags unsupported encodings and counts them.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   flush                 synchronous pipeline flush
//   in_valid/in_ready     upstream handshake (in_ready registered)
//   opcode/funct3/funct7  instruction fields
//   out_valid/out_ready   downstream handshake
//   out_operation         Operation code (0000 for illegal entries)
//   out_illegal           entry is an unsupported encoding
//   illegal_count         saturating count of accepted illegal entries
// -----------------------------------------------------------------------------
module alu_op_encoder
   import alu_pkg::*;
#(
   parameter int OPCODE_LENGTH = OP_W,
   parameter int CNT_WIDTH     = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [6:0]               opcode,
   input  logic [2:0]               funct3,
   input  logic [6:0]               funct7,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [OPCODE_LENGTH-1:0] out_operation,
   output logic                     out_illegal,
   output logic [CNT_WIDTH-1:0]     illegal_count
);

   dec_t                     w_dec;
   logic                     w_accept;
   logic [OPCODE_LENGTH:0]   w_in_data;
   logic [OPCODE_LENGTH:0]   w_out_data;
   logic                     w_ready;
   logic [CNT_WIDTH-1:0]     r_cnt;

   assign w_dec     = decode_op(opcode, funct3, funct7);
   assign w_in_data = {w_dec.illegal, OPCODE_LENGTH'(w_dec.op)};
   assign w_accept  = in_valid && w_ready && !flush;

   alu_op_skid #(
      .W (OPCODE_LENGTH + 1)
   ) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clr   (flush),
      .i_valid (in_valid),
      .o_ready (w_ready),
      .i_data  (w_in_data),
      .o_valid (out_valid),
      .i_ready (out_ready),
      .o_data  (w_out_data)
   );

   // Illegal-entry counter: saturates, survives flush
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (w_accept && w_dec.illegal && (r_cnt != {CNT_WIDTH{1'b1}})) begin
         r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
   end

   assign in_ready      = w_ready;
   assign out_operation = w_out_data[OPCODE_LENGTH-1:0];
   assign out_illegal   = w_out_data[OPCODE_LENGTH];
   assign illegal_count = r_cnt;

endmodule

// File: tb/tb_alu_op_encoder.sv
module tb_alu_op_encoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_operation;
   logic        out_illegal;
   logic [15:0] illegal_count;
   // second instance with a 2-bit counter, driven identically
   logic        s_in_ready;
   logic        s_out_valid;
   logic [3:0]  s_out_operation;
   logic        s_out_illegal;
   logic [1:0]  s_illegal_count;

   always #5 clk = ~clk;

   alu_op_encoder #(.OPCODE_LENGTH(4), .CNT_WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
      .in_ready(in_ready), .opcode(opcode), .funct3(funct3), .funct7(funct7),
      .out_valid(out_valid), .out_ready(out_ready), .out_operation(out_operation),
      .out_illegal(out_illegal), .illegal_count(illegal_count));

   alu_op_encoder #(.OPCODE_LENGTH(4), .CNT_WIDTH(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
      .in_ready(s_in_ready), .opcode(opcode), .funct3(funct3), .funct7(funct7),
      .out_valid(s_out_valid), .out_ready(out_ready), .out_operation(s_out_operation),
      .out_illegal(s_out_illegal), .illegal_count(s_illegal_count));

   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [4:0]  q[$];          // {illegal, op} entries held by the stage
   int          cnt_exp  = 0;
   int          cnt2_exp = 0;
   logic [3:0]  code_of[string];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic string alu_name(input logic [2:0] f3);
      case (f3)
         3'd0:    return "ADD";
         3'd1:    return "SLL";
         3'd2:    return "SLT";
         3'd4:    return "XOR";
         3'd5:    return "SRL";
         3'd6:    return "OR";
         3'd7:    return "AND";
         default: return "";
      endcase
   endfunction

   // Instruction mnemonic from the ISA rules; "" means unsupported
   function automatic string mnem(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
      bit is_r;
      bit is_i;
      is_r = (op == 7'h33);
      is_i = (op == 7'h13);
      if (is_r || is_i) begin
         if (f3 == 3'd3) return "";
         if (is_r || f3 == 3'd1 || f3 == 3'd5) begin
            if (f7 == 7'h00) return alu_name(f3);
            if (f7 == 7'h20 && f3 == 3'd5) return "SRA";
            if (f7 == 7'h20 && is_r && f3 == 3'd0) return "SUB";
            return "";
         end
         return alu_name(f3);
      end
      if (op == 7'h03 || op == 7'h23 || op == 7'h37 || op == 7'h17 || op == 7'h6F) return "ADD";
      if (op == 7'h67) return (f3 == 3'd0) ? "JALR" : "";
      if (op == 7'h63) begin
         case (f3)
            3'd0:    return "BEQ";
            3'd1:    return "BNE";
            3'd4:    return "BLT";
            3'd5:    return "BGE";
            default: return "";
         endcase
      end
      return "";
   endfunction

   function automatic logic [4:0] ref_entry(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
      string m;
      m = mnem(op, f3, f7);
      if (m == "") return 5'b10000;
      return {1'b0, code_of[m]};
   endfunction

   task automatic drive(input bit v, input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
      in_valid = v;
      opcode   = o;
      funct3   = f3;
      funct7   = f7;
   endtask

   task automatic check_outputs();
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
      if (q.size() > 0) begin
         chk("out_operation", 32'(out_operation), 32'(q[0][3:0]));
         chk("out_illegal", 32'(out_illegal), 32'(q[0][4]));
      end
      chk("illegal_count", 32'(illegal_count), 32'(cnt_exp));
      chk("illegal_count_w2", 32'(s_illegal_count), 32'(cnt2_exp));
   endtask

   // check current outputs, then advance one clock and update the model
   task automatic step();
      logic [4:0] e;
      bit         acc;
      bit         pop;
      check_outputs();
      e   = ref_entry(opcode, funct3, funct7);
      acc = in_valid && (q.size() < 2) && !flush && rst_n;
      pop = (q.size() > 0) && out_ready;
      @(posedge clk);
      #1;
      if (!rst_n) begin
         q.delete();
         cnt_exp  = 0;
         cnt2_exp = 0;
      end else if (flush) begin
         q.delete();
      end else begin
         if (pop) q.delete(0);
         if (acc) q.push_back(e);
      end
      if (acc && e[4]) begin
         if (cnt_exp < 65535) cnt_exp++;
         if (cnt2_exp < 3) cnt2_exp++;
      end
   endtask

   task automatic rand_instr();
      logic [6:0] o;
      logic [6:0] f7;
      case ($urandom_range(0, 10))
         0:  o = 7'h33;
         1:  o = 7'h13;
         2:  o = 7'h03;
         3:  o = 7'h23;
         4:  o = 7'h37;
         5:  o = 7'h17;
         6:  o = 7'h6F;
         7:  o = 7'h67;
         8:  o = 7'h63;
         9:  o = 7'h33;
         default: o = 7'($urandom);
      endcase
      case ($urandom_range(0, 2))
         0:       f7 = 7'h00;
         1:       f7 = 7'h20;
         default: f7 = 7'($urandom);
      endcase
      drive(($urandom_range(0, 3) != 0), o, 3'($urandom), f7);
   endtask

   initial begin
      code_of["AND"] = 4'b0000; code_of["OR"]  = 4'b0001; code_of["ADD"]  = 4'b0010;
      code_of["JALR"] = 4'b0011; code_of["SLT"] = 4'b0100; code_of["XOR"] = 4'b0101;
      code_of["SUB"] = 4'b0110; code_of["BEQ"] = 4'b1000; code_of["BNE"]  = 4'b1001;
      code_of["BLT"] = 4'b1010; code_of["BGE"] = 4'b1011; code_of["SLL"]  = 4'b1101;
      code_of["SRL"] = 4'b1110; code_of["SRA"] = 4'b1111;

      rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
      drive(1'b0, 7'h00, 3'd0, 7'h00);
      @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_operation", 32'(out_operation), 32'd0);
      chk("rst_out_illegal", 32'(out_illegal), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_illegal_count", 32'(illegal_count), 32'd0);
      rst_n = 1'b1;
      step();

      // streaming at full throughput
      drive(1'b1, 7'b0110011, 3'b000, 7'b0000000); step();
      chk("stream_add", 32'(out_operation), 32'b0010);
      drive(1'b1, 7'b0110011, 3'b000, 7'b0100000); step();
      chk("stream_sub", 32'(out_operation), 32'b0110);
      drive(1'b1, 7'b0010011, 3'b101, 7'b0100000); step();
      chk("stream_srai", 32'(out_operation), 32'b1111);
      drive(1'b1, 7'b1100011, 3'b101, 7'b0000000); step();
      chk("stream_bge", 32'(out_operation), 32'b1011);
      chk("stream_valid", 32'(out_valid), 32'd1);

      // illegal encodings
      drive(1'b1, 7'b0110011, 3'b011, 7'b0000000); step();
      chk("sltu_illegal", 32'({out_illegal, out_operation}), 32'b10000);
      drive(1'b1, 7'b1100011, 3'b010, 7'b0000000); step();
      chk("br010_illegal", 32'({out_illegal, out_operation}), 32'b10000);
      drive(1'b1, 7'b1111111, 3'b000, 7'b0000000); step();
      chk("opc7f_illegal", 32'({out_illegal, out_operation}), 32'b10000);
      drive(1'b0, 7'h00, 3'd0, 7'h00); step(); step();
      chk("illegal_count_3", 32'(illegal_count), 32'd3);

      // backpressure: three offered, two taken
      out_ready = 1'b0;
      drive(1'b1, 7'b0110011, 3'b100, 7'b0000000); step();
      drive(1'b1, 7'b0110011, 3'b110, 7'b0000000); step();
      chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      drive(1'b1, 7'b0110011, 3'b111, 7'b0000000); step();
      drive(1'b0, 7'h00, 3'd0, 7'h00);
      out_ready = 1'b1;
      step(); step(); step(); step();

      // flush with both entries full and a same-cycle input
      out_ready = 1'b0;
      drive(1'b1, 7'b0110011, 3'b001, 7'b0000000); step();
      drive(1'b1, 7'b0110011, 3'b101, 7'b0100000); step();
      drive(1'b1, 7'b1111111, 3'b000, 7'b0000000);
      flush = 1'b1; step();
      flush = 1'b0;
      drive(1'b0, 7'h00, 3'd0, 7'h00);
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      chk("flush_in_ready", 32'(in_ready), 32'd1);
      chk("flush_count", 32'(illegal_count), 32'd3);
      out_ready = 1'b1;
      step();

      // counter saturation on the 2-bit instance
      rst_n = 1'b0; step(); rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 7'b1100111, 3'($urandom_range(1, 7)), 7'h00); step();
      end
      drive(1'b0, 7'h00, 3'd0, 7'h00); step();
      chk("sat_count_w2", 32'(s_illegal_count), 32'd3);
      chk("sat_count_w16", 32'(illegal_count), 32'd5);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         rand_instr();
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 24) == 0);
         step();
      end
      flush = 1'b0;

      // async reset off a clock edge while stalled and full
      out_ready = 1'b0;
      drive(1'b1, 7'b0000011, 3'b010, 7'h00); step(); step();
      drive(1'b0, 7'h00, 3'd0, 7'h00);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_out_operation", 32'(out_operation), 32'd0);
      chk("arst_in_ready", 32'(in_ready), 32'd1);
      chk("arst_count", 32'(illegal_count), 32'd0);
      q.delete();
      cnt_exp  = 0;
      cnt2_exp = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      drive(1'b1, 7'b1100111, 3'b000, 7'h00); step();
      drive(1'b0, 7'h00, 3'd0, 7'h00); step(); step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
